load_store_unit: RTL

Parametrised load/store unit between the core control logic and the memory bus, replacing direct bus driving by the dataflow. Accepts one load or store request at a time and drives the bus with naturally aligned addresses. It splits accesses that cross a bus-word boundary into two bus beats, and sign- or zero-extends load results. It also raises a misalignment or illegal-size fault instead of touching the bus when the configuration forbids the access.

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between core control and the memory bus: aligned bus beats,
// two-beat splitting of boundary-crossing accesses, load extension and fault reporting.
module load_store_unit #(
  parameter int unsigned DATA_SIZE        = 32,
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   op_rd_en,
  input  logic                   op_wr_en,
  input  logic [DATA_SIZE-1:0]   op_addr,
  input  logic [2:0]             op_funct3,
  input  logic [DATA_SIZE-1:0]   op_wr_data,
  output logic [DATA_SIZE-1:0]   op_rd_data,
  output logic                   op_busy,
  output logic                   op_done,
  output logic                   op_fault,
  input  logic [DATA_SIZE-1:0]   rd_data,
  output logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   mem_addr,
  input  logic                   mem_busy,
  output logic                   mem_rd_en,
  output logic                   mem_wr_en,
  output logic [DATA_SIZE/8-1:0] mem_byte_en
);
  localparam int unsigned BYTE_NUM = DATA_SIZE / 8;
  localparam int unsigned OFF_W    = $clog2(BYTE_NUM);
  localparam logic [2*BYTE_NUM-1:0] ONE_L = 1;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, state_n;

  logic [DATA_SIZE-1:0]   addr_q, addr_n, wdata_q, wdata_n, acc_q, acc_n;
  logic [2:0]             f3_q, f3_n;
  logic                   wr_q, wr_n;
  logic [DATA_SIZE-1:0]   rd_res_n, wr_data_n, mem_addr_n;
  logic                   busy_n, done_n, fault_n, rd_en_n, wr_en_n;
  logic [BYTE_NUM-1:0]    be_n;

  logic [DATA_SIZE-1:0]   src_addr, src_wdata, base;
  logic [2:0]             src_f3;
  int unsigned            off, size;
  logic [2*BYTE_NUM-1:0]  lanes;
  logic [2*DATA_SIZE-1:0] lane_data;
  logic                   split, req_fault;

  function automatic logic [DATA_SIZE-1:0] extend(input logic [DATA_SIZE-1:0] d,
                                                  input logic [2:0] f3);
    int unsigned bits, sh;
    logic [DATA_SIZE-1:0] t;
    logic signed [DATA_SIZE-1:0] s;
    bits = 32'd8 << f3[1:0];
    sh   = (bits >= DATA_SIZE) ? 0 : DATA_SIZE - bits;
    t    = d << sh;
    if (f3[2]) return t >> sh;
    s = $signed(t) >>> sh;
    return s;
  endfunction

  // Decode from the live request while idle, from the captured request during beats;
  // lane masks and shifted data span two bus words so the upper half is the BEAT1 view.
  always_comb begin
    src_addr  = (state == IDLE) ? op_addr    : addr_q;
    src_wdata = (state == IDLE) ? op_wr_data : wdata_q;
    src_f3    = (state == IDLE) ? op_funct3  : f3_q;
    off       = 32'(src_addr[OFF_W-1:0]);
    size      = 32'd1 << src_f3[1:0];
    base      = src_addr & ~DATA_SIZE'(BYTE_NUM - 1);
    lanes     = ((ONE_L << size) - ONE_L) << off;
    lane_data = {{DATA_SIZE{1'b0}}, src_wdata} << (8 * off);
    split     = (off + size) > BYTE_NUM;
    req_fault = (op_rd_en && op_wr_en) || (op_funct3 == 3'b111) ||
                ((DATA_SIZE == 32) && ((op_funct3[1:0] == 2'b11) || (op_funct3 == 3'b110))) ||
                (op_wr_en && op_funct3[2]) ||
                ((ALLOW_MISALIGNED == 0) && ((src_addr[3:0] & 4'(size - 1)) != 4'd0));
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    acc_n      = acc_q;
    f3_n       = f3_q;
    wr_n       = wr_q;
    rd_res_n   = op_rd_data;
    done_n     = 1'b0;
    fault_n    = 1'b0;
    wr_data_n  = wr_data;
    mem_addr_n = mem_addr;
    rd_en_n    = mem_rd_en;
    wr_en_n    = mem_wr_en;
    be_n       = mem_byte_en;
    unique case (state)
      IDLE: begin
        if (op_rd_en || op_wr_en) begin
          addr_n   = op_addr;
          wdata_n  = op_wr_data;
          f3_n     = op_funct3;
          wr_n     = op_wr_en;
          rd_res_n = '0;
          if (req_fault) begin
            state_n = RESP;
            fault_n = 1'b1;
          end else begin
            state_n    = BEAT0;
            mem_addr_n = base;
            be_n       = lanes[BYTE_NUM-1:0];
            wr_data_n  = lane_data[DATA_SIZE-1:0];
            rd_en_n    = !op_wr_en;
            wr_en_n    = op_wr_en;
          end
        end
      end
      BEAT0: begin
        if (!mem_busy) begin
          if (split) begin
            state_n    = BEAT1;
            mem_addr_n = base + DATA_SIZE'(BYTE_NUM);
            be_n       = lanes[2*BYTE_NUM-1:BYTE_NUM];
            wr_data_n  = lane_data[2*DATA_SIZE-1:DATA_SIZE];
            acc_n      = rd_data >> (8 * off);
          end else begin
            state_n    = RESP;
            done_n     = 1'b1;
            rd_res_n   = wr_q ? '0 : extend(rd_data >> (8 * off), f3_q);
            mem_addr_n = '0;
            be_n       = '0;
            wr_data_n  = '0;
            rd_en_n    = 1'b0;
            wr_en_n    = 1'b0;
          end
        end
      end
      BEAT1: begin
        if (!mem_busy) begin
          state_n    = RESP;
          done_n     = 1'b1;
          rd_res_n   = wr_q ? '0 : extend(acc_q | (rd_data << (8 * (BYTE_NUM - off))), f3_q);
          mem_addr_n = '0;
          be_n       = '0;
          wr_data_n  = '0;
          rd_en_n    = 1'b0;
          wr_en_n    = 1'b0;
        end
      end
      RESP: begin
        state_n  = IDLE;
        rd_res_n = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      f3_q        <= '0;
      wr_q        <= 1'b0;
      op_rd_data  <= '0;
      op_busy     <= 1'b0;
      op_done     <= 1'b0;
      op_fault    <= 1'b0;
      wr_data     <= '0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_byte_en <= '0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      acc_q       <= acc_n;
      f3_q        <= f3_n;
      wr_q        <= wr_n;
      op_rd_data  <= rd_res_n;
      op_busy     <= busy_n;
      op_done     <= done_n;
      op_fault    <= fault_n;
      wr_data     <= wr_data_n;
      mem_addr    <= mem_addr_n;
      mem_rd_en   <= rd_en_n;
      mem_wr_en   <= wr_en_n;
      mem_byte_en <= be_n;
    end
  end
endmodule
